// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one async_transmitter among NREQ byte requesters. Arbitration is
//   round-robin and works per packet. A granted requester keeps the
//   transmitter until its byte marked req_last has been sent. The block
//   sequences TxD_start against TxD_busy and has two watchdogs: one for a
//   transmitter that never reports busy, and one for a locked requester
//   that stops offering bytes in the middle of a packet.
//
// Ports
//   clk          transmitter clock (same clock as async_transmitter)
//   rst_n        asynchronous active-low reset
//   req_valid    [NREQ]    requester i offers a byte
//   req_data     [8*NREQ]  packed bytes, requester i at [8i+7:8i]
//   req_last     [NREQ]    the offered byte ends requester i's packet
//   req_ready    [NREQ]    one-hot, 1-cycle pulse: byte of requester i taken
//   tx_start     1-cycle pulse to TxD_start
//   tx_data      byte to TxD_data, held from tx_start until the byte is done
//   tx_busy      TxD_busy from the transmitter
//   grant_id     current owner (meaningful while grant_active)
//   grant_active a packet lock is held
//   err_timeout  sticky: busy never rose or packet stalled; cleared by reset

module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int BUSY_TIMEOUT = 64,
  parameter int PKT_TIMEOUT  = 4096,
  localparam int IDW         = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [IDW-1:0]    grant_id,
  output logic              grant_active,
  output logic              err_timeout
);

  localparam int BCW = $clog2(BUSY_TIMEOUT + 1);
  localparam int SCW = $clog2(PKT_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCEPT  = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;

  logic [2:0]      state;
  logic [IDW-1:0]  rr_ptr;
  logic            last_r;
  logic [BCW-1:0]  busy_cnt;
  logic [SCW-1:0]  stall_cnt;

  logic [7:0]      req_bytes [NREQ];
  logic [7:0]      sel_byte;
  logic            sel_last;
  logic            sel_valid;
  logic [IDW-1:0]  next_ptr;

  logic [2*NREQ-1:0] dbl_valid;
  logic [NREQ-1:0]   rot_valid;
  logic [IDW:0]      pick_sum;
  logic              pick_found;
  logic [IDW-1:0]  pick_id;

  // Split the packed byte bus so the owner's byte can be selected by index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_bytes[i] = req_data[i*8 +: 8];
    end
  end

  // Signals of the current owner, and the pointer value that makes the
  // owner the lowest-priority requester at the next arbitration.
  always_comb begin
    sel_byte  = req_bytes[grant_id];
    sel_last  = req_last[grant_id];
    sel_valid = req_valid[grant_id];
    next_ptr  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Round-robin pick. The valid vector is rotated so that the requester at
  // rr_ptr lands on bit 0. The first set bit is then the winner. Its
  // rotated position is mapped back to a real index modulo NREQ.
  always_comb begin
    dbl_valid  = {req_valid, req_valid} >> rr_ptr;
    rot_valid  = dbl_valid[NREQ-1:0];
    pick_found = 1'b0;
    pick_id    = '0;
    pick_sum   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!pick_found && rot_valid[j]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr} + (IDW+1)'(j);
        if (pick_sum >= (IDW+1)'(NREQ)) begin
          pick_sum = pick_sum - (IDW+1)'(NREQ);
        end
        pick_id = pick_sum[IDW-1:0];
      end
    end
  end

  // Main sequencer. req_ready and tx_start are single-cycle pulses, so they
  // default low every cycle. "Done handling" returns to IDLE. It releases the
  // lock only after the last byte of a packet. A byte whose busy never rose
  // is counted as sent, so one dead transfer cannot wedge the requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      req_ready    <= '0;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      grant_id     <= '0;
      grant_active <= 1'b0;
      err_timeout  <= 1'b0;
      rr_ptr       <= '0;
      last_r       <= 1'b0;
      busy_cnt     <= '0;
      stall_cnt    <= '0;
    end else begin
      req_ready <= '0;
      tx_start  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_active) begin
            if (sel_valid) begin
              stall_cnt <= '0;
              state     <= S_ACCEPT;
            end else if (stall_cnt == SCW'(PKT_TIMEOUT - 1)) begin
              grant_active <= 1'b0;
              err_timeout  <= 1'b1;
              stall_cnt    <= '0;
              rr_ptr       <= next_ptr;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end else if (pick_found) begin
            grant_id     <= pick_id;
            grant_active <= 1'b1;
            stall_cnt    <= '0;
            state        <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          tx_data             <= sel_byte;
          last_r              <= sel_last;
          req_ready[grant_id] <= 1'b1;
          state               <= S_START;
        end
        S_START: begin
          // A frame that was started before a reset may still be running.
          if (!tx_busy) begin
            tx_start <= 1'b1;
            busy_cnt <= '0;
            state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (tx_busy) begin
            state <= S_WAIT_LO;
          end else if (busy_cnt == BCW'(BUSY_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
            if (last_r) begin
              grant_active <= 1'b0;
              rr_ptr       <= next_ptr;
            end
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            state <= S_IDLE;
            if (last_r) begin
              grant_active <= 1'b0;
              rr_ptr       <= next_ptr;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
